// File: rtl/axis_jtag_master.sv
// AXI-Stream to JTAG master: resets the TAP, loads IR_CODE, then shifts one 32-bit DR word per s_axis beat.
// Latency: 37 TCK periods (2*CLK_DIV aclk each) from s_axis accept to m_axis_tvalid; init is 18 TCKs for IR_WIDTH=6.
// Backpressure: s_axis_tready only in READY with m_axis empty, so a captured word is never overwritten.
// Optional macro AXIS_JTAG_MASTER_LOOPBACK_EN: capture the driven TDI instead of jtag_tdo.
module axis_jtag_master #(
  parameter int unsigned         CLK_DIV  = 4,
  parameter int unsigned         IR_WIDTH = 6,
  parameter logic [IR_WIDTH-1:0] IR_CODE  = 6'h02
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        jtag_tck,
  output logic        jtag_tms,
  output logic        jtag_tdi,
  input  logic        jtag_tdo,
  output logic        busy
);

  typedef enum logic [1:0] {TLR, IR_SEQ, READY, DR_SEQ} state_t;

  // Step indices (one step = one TCK period) inside each TAP sequence.
  localparam logic [7:0] DIV_MAX  = 8'(CLK_DIV - 1);
  localparam logic [7:0] TLR_LAST = 8'd5;
  localparam logic [7:0] IR_BIT0  = 8'd4;
  localparam logic [7:0] IR_BITN  = 8'(IR_WIDTH + 3);
  localparam logic [7:0] IR_LAST  = 8'(IR_WIDTH + 5);
  localparam logic [7:0] DR_BIT0  = 8'd3;
  localparam logic [7:0] DR_BITN  = 8'd34;
  localparam logic [7:0] DR_LAST  = 8'd36;

  state_t      state_q, state_d;
  logic [7:0]  step_q, step_d;
  logic [7:0]  div_q, div_d;
  logic        tck_q, tck_d;
  logic        tms_q, tms_d;
  logic        tdi_q, tdi_d;
  logic [31:0] tx_q, tx_d;
  logic [31:0] rx_q, rx_d;
  logic [31:0] mdat_q, mdat_d;
  logic        mvld_q, mvld_d;
  logic        s_rdy;
  logic        tdo_smp;

`ifdef AXIS_JTAG_MASTER_LOOPBACK_EN
  logic unused_tdo;
  assign unused_tdo = jtag_tdo;
  assign tdo_smp    = tdi_q;
`else
  assign tdo_smp    = jtag_tdo;
`endif

  // TMS/TDI pair to present during a given step of a sequence.
  function automatic logic [1:0] tap_bits(input state_t st, input logic [7:0] step,
                                          input logic [31:0] word);
    logic                tms;
    logic                tdi;
    logic [IR_WIDTH-1:0] ir_sh;
    logic [31:0]         dr_sh;
    tms   = 1'b0;
    tdi   = 1'b0;
    ir_sh = IR_CODE >> (step - IR_BIT0);
    dr_sh = word >> (step - DR_BIT0);
    case (st)
      TLR:    tms = (step != TLR_LAST);
      IR_SEQ: begin
        if (step < IR_BIT0) begin
          tms = (step < 8'd2);
        end else if (step <= IR_BITN) begin
          tdi = ir_sh[0];
          tms = (step == IR_BITN);
        end else begin
          tms = (step != IR_LAST);
        end
      end
      DR_SEQ: begin
        if (step < DR_BIT0) begin
          tms = (step == 8'd0);
        end else if (step <= DR_BITN) begin
          tdi = dr_sh[0];
          tms = (step == DR_BITN);
        end else begin
          tms = (step != DR_LAST);
        end
      end
      default: ;
    endcase
    return {tms, tdi};
  endfunction

  assign s_rdy = (state_q == READY) && !mvld_q;

  // State register and all datapath registers.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= TLR;
      step_q  <= '0;
      div_q   <= '0;
      tck_q   <= 1'b0;
      tms_q   <= 1'b1;
      tdi_q   <= 1'b0;
      tx_q    <= '0;
      rx_q    <= '0;
      mdat_q  <= '0;
      mvld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      div_q   <= div_d;
      tck_q   <= tck_d;
      tms_q   <= tms_d;
      tdi_q   <= tdi_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      mdat_q  <= mdat_d;
      mvld_q  <= mvld_d;
    end
  end

  // Next state: TCK divider, step sequencing, TDO capture and stream handshakes.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    div_d   = div_q;
    tck_d   = tck_q;
    tms_d   = tms_q;
    tdi_d   = tdi_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    mdat_d  = mdat_q;
    mvld_d  = mvld_q;

    if (mvld_q && m_axis_tready) mvld_d = 1'b0;

    case (state_q)
      READY: begin
        tck_d = 1'b0;
        div_d = '0;
        tms_d = 1'b0;
        tdi_d = 1'b0;
        if (s_axis_tvalid && s_rdy) begin
          tx_d           = s_axis_tdata;
          state_d        = DR_SEQ;
          step_d         = '0;
          {tms_d, tdi_d} = tap_bits(DR_SEQ, 8'd0, s_axis_tdata);
        end
      end
      default: begin
        if (div_q == DIV_MAX) begin
          div_d = '0;
          tck_d = ~tck_q;
          if (!tck_q) begin
            // Rising TCK: capture TDO during the 32 DR shift steps.
            if (state_q == DR_SEQ && step_q >= DR_BIT0 && step_q <= DR_BITN)
              rx_d = {tdo_smp, rx_q[31:1]};
          end else begin
            // Falling TCK: advance to the next step or finish the sequence.
            if ((state_q == TLR && step_q == TLR_LAST) ||
                (state_q == IR_SEQ && step_q == IR_LAST) ||
                (state_q == DR_SEQ && step_q == DR_LAST)) begin
              step_d = '0;
              if (state_q == TLR) begin
                state_d        = IR_SEQ;
                {tms_d, tdi_d} = tap_bits(IR_SEQ, 8'd0, tx_q);
              end else begin
                state_d = READY;
                tms_d   = 1'b0;
                tdi_d   = 1'b0;
                if (state_q == DR_SEQ) begin
                  mdat_d = rx_q;
                  mvld_d = 1'b1;
                end
              end
            end else begin
              step_d         = step_q + 8'd1;
              {tms_d, tdi_d} = tap_bits(state_q, step_q + 8'd1, tx_q);
            end
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
    endcase
  end

  assign s_axis_tready = s_rdy;
  assign m_axis_tdata  = mdat_q;
  assign m_axis_tvalid = mvld_q;
  assign jtag_tck      = tck_q;
  assign jtag_tms      = tms_q;
  assign jtag_tdi      = tdi_q;
  assign busy          = (state_q != READY);

endmodule

// File: tb/tb_axis_jtag_master.sv
// Directed bench for axis_jtag_master: init sequence, bypass echo, backpressure, mid-word reset, CLK_DIV=2 timing.
// A second instance with CLK_DIV=2 drives TDO as ~TCK, so only a sample taken on the rising cycle yields 1.
module tb_axis_jtag_master;

  localparam logic [31:0] W1 = 32'hA5C3_0F81;
  localparam logic [31:0] W2 = 32'h3C5A_9617;
  localparam logic [31:0] W3 = 32'hDEAD_BEEF;
  localparam logic [31:0] W4 = 32'h1234_5678;
`ifdef AXIS_JTAG_MASTER_LOOPBACK_EN
  localparam logic [31:0] EXP1 = W1;
  localparam logic [31:0] EXP2 = W2;
  localparam logic [31:0] EXP4 = W4;
`else
  localparam logic [31:0] EXP1 = 32'h4B86_1F02;
  localparam logic [31:0] EXP2 = 32'h78B5_2C2E;
  localparam logic [31:0] EXP4 = 32'hFFFF_FFFF;
`endif

  logic aclk = 1'b0;
  logic areset = 1'b1;
  logic rst2 = 1'b1;
  always #5 aclk = ~aclk;

  logic [31:0] s_tdata, m_tdata, s_tdata2, m_tdata2;
  logic        s_tvalid, s_tready, m_tvalid, m_tready;
  logic        s_tvalid2, s_tready2, m_tvalid2, m_tready2;
  logic        tck, tms, tdi, busy, tck2, tms2, tdi2, busy2, tdo2;
  logic        tdo = 1'b0;
  logic        bp = 1'b0;

  axis_jtag_master dut (
    .aclk(aclk), .areset(areset),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .jtag_tck(tck), .jtag_tms(tms), .jtag_tdi(tdi), .jtag_tdo(tdo), .busy(busy)
  );

  axis_jtag_master #(.CLK_DIV(2)) dut2 (
    .aclk(aclk), .areset(rst2),
    .s_axis_tdata(s_tdata2), .s_axis_tvalid(s_tvalid2), .s_axis_tready(s_tready2),
    .m_axis_tdata(m_tdata2), .m_axis_tvalid(m_tvalid2), .m_axis_tready(m_tready2),
    .jtag_tck(tck2), .jtag_tms(tms2), .jtag_tdi(tdi2), .jtag_tdo(tdo2), .busy(busy2)
  );

  // One-bit bypass target: latch TDI on rising TCK, present it on falling TCK.
  always @(posedge tck) bp <= tdi;
  always @(negedge tck) tdo <= bp;
  assign tdo2 = ~tck2;

  // Log TMS/TDI seen at every rising TCK of the main instance.
  int   n_tck = 0;
  logic tms_log [0:511];
  logic tdi_log [0:511];
  always @(posedge tck) begin
    if (n_tck < 512) begin
      tms_log[n_tck] = tms;
      tdi_log[n_tck] = tdi;
    end
    n_tck++;
  end

  int n_mv = 0;
  always @(posedge m_tvalid) n_mv++;

  // Phase widths of the CLK_DIV=2 instance.
  time t_r2 = 0, t_f2 = 0;
  int  nr2 = 0, nf2 = 0;
  time hi_w [0:63];
  time lo_w [0:63];
  always @(posedge tck2) if (!rst2) begin
    if (nf2 > 0 && nr2 < 64) lo_w[nr2] = $time - t_f2;
    t_r2 = $time;
    nr2++;
  end
  always @(negedge tck2) if (!rst2) begin
    if (nf2 < 64) hi_w[nf2] = $time - t_r2;
    t_f2 = $time;
    nf2++;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] tms_vec(input int base, input int n);
    logic [63:0] v = '0;
    for (int i = 0; i < n; i++) v[i] = tms_log[base + i];
    return v;
  endfunction

  function automatic logic [63:0] tdi_vec(input int base, input int n);
    logic [63:0] v = '0;
    for (int i = 0; i < n; i++) v[i] = tdi_log[base + i];
    return v;
  endfunction

  task automatic wait_idle(input string tag);
    logic ok = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge aclk);
      if (!busy) begin ok = 1'b1; break; end
    end
    chk(tag, 64'(ok), 64'd1);
  endtask

  task automatic wait_mv(input string tag);
    logic ok = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge aclk);
      if (m_tvalid) begin ok = 1'b1; break; end
    end
    chk(tag, 64'(ok), 64'd1);
  endtask

  // Offer a word from a negedge; returns the TCK log index at acceptance.
  task automatic send(input logic [31:0] w, output int b);
    logic ok = 1'b0;
    s_tdata  = w;
    s_tvalid = 1'b1;
    b = n_tck;
    for (int c = 0; c < 3000; c++) begin
      if (s_tready) begin
        @(posedge aclk);
        b  = n_tck;
        ok = 1'b1;
        break;
      end
      @(negedge aclk);
    end
    #1 s_tvalid = 1'b0;
    chk("send_accept", 64'(ok), 64'd1);
  endtask

  task automatic init_checks(input int base, input string tag);
    wait_idle({tag, "_done"});
    chk({tag, "_tck_count"}, 64'(n_tck - base), 64'd18);
    chk({tag, "_tms"}, tms_vec(base, 18), 64'h180DF);
    chk({tag, "_tdi"}, tdi_vec(base, 18), 64'h00800);
    chk({tag, "_tck_idle"}, 64'(tck), 64'd0);
  endtask

  initial begin
    int base;
    int seen_rdy;
    int seen_busy;
    int mv0;
    int bad;
    logic ok;
    s_tdata = '0; s_tvalid = 1'b0; m_tready = 1'b0;
    s_tdata2 = '0; s_tvalid2 = 1'b0; m_tready2 = 1'b0;
    repeat (3) @(negedge aclk);

    chk("rst_tck", 64'(tck), 64'd0);
    chk("rst_tms", 64'(tms), 64'd1);
    chk("rst_tdi", 64'(tdi), 64'd0);
    chk("rst_s_tready", 64'(s_tready), 64'd0);
    chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_m_tdata", 64'(m_tdata), 64'd0);
    chk("rst_busy", 64'(busy), 64'd1);

    base = n_tck;
    areset = 1'b0;
    init_checks(base, "init");
    chk("ready_s_tready", 64'(s_tready), 64'd1);

    // First word through the bypass target.
    send(W1, base);
    wait_mv("w1_valid");
    chk("w1_tck_count", 64'(n_tck - base), 64'd37);
    chk("w1_tdata", 64'(m_tdata), 64'(EXP1));
    chk("w1_tms", tms_vec(base, 37), 64'h0C_0000_0001);
    chk("w1_tdi", tdi_vec(base, 37), {32'b0, W1} << 3);

    // Backpressure: second word must wait while the first is unacknowledged.
    s_tdata = W2; s_tvalid = 1'b1;
    seen_rdy = 0; seen_busy = 0;
    repeat (60) begin
      @(negedge aclk);
      if (s_tready) seen_rdy++;
      if (busy) seen_busy++;
    end
    chk("bp_s_tready", 64'(seen_rdy), 64'd0);
    chk("bp_no_dr", 64'(seen_busy), 64'd0);
    chk("bp_hold_tdata", 64'(m_tdata), 64'(EXP1));
    m_tready = 1'b1;
    chk("ack_cycle_no_accept", 64'(s_tready), 64'd0);
    @(posedge aclk);
    #1 m_tready = 1'b0;
    @(negedge aclk);
    chk("w1_ack_clears", 64'(m_tvalid), 64'd0);
    send(W2, base);
    wait_mv("w2_valid");
    chk("w2_tck_count", 64'(n_tck - base), 64'd37);
    chk("w2_tdata", 64'(m_tdata), 64'(EXP2));
    m_tready = 1'b1;
    @(posedge aclk);
    #1 m_tready = 1'b0;
    @(negedge aclk);
    chk("w2_ack_clears", 64'(m_tvalid), 64'd0);

    // Reset in the middle of DR shift bit 15.
    mv0 = n_mv;
    send(W3, base);
    ok = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge aclk);
      if (n_tck - base >= 19) begin ok = 1'b1; break; end
    end
    chk("mid_reach_bit15", 64'(ok), 64'd1);
    chk("mid_pre_tdi", 64'(tdi), 64'd1);
    chk("mid_pre_tck", 64'(tck), 64'd1);
    areset = 1'b1;
    #1;
    chk("mid_rst_tck", 64'(tck), 64'd0);
    chk("mid_rst_tms", 64'(tms), 64'd1);
    chk("mid_rst_tdi", 64'(tdi), 64'd0);
    chk("mid_rst_s_tready", 64'(s_tready), 64'd0);
    chk("mid_rst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("mid_rst_m_tdata", 64'(m_tdata), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd1);
    repeat (3) @(negedge aclk);
    base = n_tck;
    areset = 1'b0;
    init_checks(base, "reinit");
    chk("mid_no_word", 64'(n_mv - mv0), 64'd0);

    // CLK_DIV=2 instance: phase widths and sample point.
    rst2 = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge aclk);
      if (!busy2) begin ok = 1'b1; break; end
    end
    chk("div2_init_done", 64'(ok), 64'd1);
    chk("div2_tck_count", 64'(nr2), 64'd18);
    bad = 0;
    for (int k = 0; k < 18; k++) if (hi_w[k] != 20) bad++;
    for (int k = 1; k < 18; k++) if (lo_w[k] != 20) bad++;
    chk("div2_phase_errors", 64'(bad), 64'd0);
    chk("div2_high0", 64'(hi_w[0]), 64'd20);
    s_tdata2 = W4; s_tvalid2 = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (s_tready2) begin @(posedge aclk); ok = 1'b1; break; end
      @(negedge aclk);
    end
    #1 s_tvalid2 = 1'b0;
    chk("div2_accept", 64'(ok), 64'd1);
    ok = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge aclk);
      if (m_tvalid2) begin ok = 1'b1; break; end
    end
    chk("div2_valid", 64'(ok), 64'd1);
    chk("div2_tdata", 64'(m_tdata2), 64'(EXP4));
    chk("div2_dr_high", 64'(hi_w[40]), 64'd20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
